// File: rtl/audio_i2s_codec_if.sv
`default_nettype none
// ============================================================================
// Module      : audio_i2s_codec_if
// Description : I2S serial-port master for an audio codec. Waits for PLL
//               lock, then generates BCLK/LRCK, serialises stereo DAC
//               samples and deserialises stereo ADC samples (standard I2S,
//               one-bit delay, MSB first). Valid/ready sample interface on
//               the DSP side with a single-entry DAC buffer.
// Ports       : clk, rst_n             - clock, async active-low reset
//               i_pll_locked           - PLL lock (asynchronous)
//               i_dac_left/right/valid - DAC sample pair offer
//               o_dac_ready            - DAC buffer free
//               o_dac_underrun         - frame started with empty buffer
//               o_adc_left/right/valid - captured ADC pair, valid pulse
//               o_aud_bclk/lrck/dacdat - codec serial outputs
//               i_aud_adcdat           - codec ADC serial data
//               o_running              - high while in RUN
// Revision    : 1.0 - initial release
// ============================================================================
module audio_i2s_codec_if #(
  parameter int SAMPLE_W = 16,
  parameter int SLOT_W   = 32,
  parameter int BCLK_DIV = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_pll_locked,
  input  logic [SAMPLE_W-1:0] i_dac_left,
  input  logic [SAMPLE_W-1:0] i_dac_right,
  input  logic                i_dac_valid,
  output logic                o_dac_ready,
  output logic                o_dac_underrun,
  output logic [SAMPLE_W-1:0] o_adc_left,
  output logic [SAMPLE_W-1:0] o_adc_right,
  output logic                o_adc_valid,
  output logic                o_aud_bclk,
  output logic                o_aud_lrck,
  output logic                o_aud_dacdat,
  input  logic                i_aud_adcdat,
  output logic                o_running
);

  localparam int c_DIV_W = $clog2(BCLK_DIV);
  localparam int c_BIT_W = $clog2(2 * SLOT_W);
  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(BCLK_DIV - 1);
  localparam logic [c_DIV_W-1:0] c_DIV_HALF = c_DIV_W'(BCLK_DIV / 2);
  localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(2 * SLOT_W - 1);
  localparam logic [c_BIT_W-1:0] c_SLOT     = c_BIT_W'(SLOT_W);
  localparam logic [c_BIT_W-1:0] c_SAMP     = c_BIT_W'(SAMPLE_W);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  logic                r_lock_meta;
  logic                r_lock_s;
  state_t              r_state;
  logic                r_running;
  logic [c_DIV_W-1:0]  r_div_cnt;
  logic [c_BIT_W-1:0]  r_bit_cnt;
  logic                r_buf_full;
  logic [SAMPLE_W-1:0] r_buf_l;
  logic [SAMPLE_W-1:0] r_buf_r;
  logic [SAMPLE_W-1:0] r_dac_sh_l;
  logic [SAMPLE_W-1:0] r_dac_sh_r;
  logic [SAMPLE_W-1:0] r_adc_sh_l;
  logic [SAMPLE_W-1:0] r_adc_sh_r;
  logic [SAMPLE_W-1:0] r_adc_l;
  logic [SAMPLE_W-1:0] r_adc_r;
  logic                r_adc_valid;
  logic                r_underrun;
  logic                r_bclk;
  logic                r_lrck;
  logic                r_dacdat;

  logic                w_run;
  logic                w_fall;
  logic                w_rise;
  logic                w_right;
  logic [c_BIT_W-1:0]  w_s;
  logic                w_data_bit;
  logic                w_frame_start;
  logic                w_hs;
  logic [SAMPLE_W-1:0] w_adc_l_nxt;
  logic [SAMPLE_W-1:0] w_adc_r_nxt;

  // RUN is only effective while the synchronised lock is still asserted, so
  // the cycle in which lock disappears produces no BCLK events.
  assign w_run         = (r_state == ST_RUN) && r_lock_s;
  assign w_fall        = w_run && (r_div_cnt == '0);
  assign w_rise        = w_run && (r_div_cnt == c_DIV_HALF);
  assign w_right       = (r_bit_cnt >= c_SLOT);
  assign w_s           = w_right ? (r_bit_cnt - c_SLOT) : r_bit_cnt;
  // Slot bit 0 is the I2S delay bit; data occupies slot bits 1..SAMPLE_W.
  assign w_data_bit    = (w_s != '0) && (w_s <= c_SAMP);
  assign w_frame_start = w_fall && (r_bit_cnt == '0);
  assign w_hs          = i_dac_valid && !r_buf_full;
  assign w_adc_l_nxt   = (r_adc_sh_l << 1) | SAMPLE_W'(i_aud_adcdat);
  assign w_adc_r_nxt   = (r_adc_sh_r << 1) | SAMPLE_W'(i_aud_adcdat);

  assign o_dac_ready    = !r_buf_full;
  assign o_dac_underrun = r_underrun;
  assign o_adc_left     = r_adc_l;
  assign o_adc_right    = r_adc_r;
  assign o_adc_valid    = r_adc_valid;
  assign o_aud_bclk     = r_bclk;
  assign o_aud_lrck     = r_lrck;
  assign o_aud_dacdat   = r_dacdat;
  assign o_running      = r_running;

  // Two-flop synchroniser for the asynchronous PLL lock indicator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
    end else begin
      r_lock_meta <= i_pll_locked;
      r_lock_s    <= r_lock_meta;
    end
  end

  // Single-entry DAC buffer. A handshake can only happen while empty, so a
  // handshake coinciding with a frame load (which then loads zeros) leaves
  // the buffer full with the new pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf_full <= 1'b0;
      r_buf_l    <= '0;
      r_buf_r    <= '0;
    end else if (w_hs) begin
      r_buf_full <= 1'b1;
      r_buf_l    <= i_dac_left;
      r_buf_r    <= i_dac_right;
    end else if (w_frame_start) begin
      r_buf_full <= 1'b0;
    end
  end

  // Frame controller: state, BCLK divider, bit counter, serialiser and
  // deserialiser.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_running   <= 1'b0;
      r_div_cnt   <= '0;
      r_bit_cnt   <= '0;
      r_bclk      <= 1'b0;
      r_lrck      <= 1'b0;
      r_dacdat    <= 1'b0;
      r_dac_sh_l  <= '0;
      r_dac_sh_r  <= '0;
      r_adc_sh_l  <= '0;
      r_adc_sh_r  <= '0;
      r_adc_l     <= '0;
      r_adc_r     <= '0;
      r_adc_valid <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_adc_valid <= 1'b0;
      r_underrun  <= 1'b0;
      if (!w_run) begin
        // IDLE, or RUN with lock lost: abandon the frame and park outputs.
        r_div_cnt  <= '0;
        r_bit_cnt  <= '0;
        r_bclk     <= 1'b0;
        r_lrck     <= 1'b0;
        r_dacdat   <= 1'b0;
        r_dac_sh_l <= '0;
        r_dac_sh_r <= '0;
        r_adc_sh_l <= '0;
        r_adc_sh_r <= '0;
        r_state    <= r_lock_s ? ST_RUN : ST_IDLE;
        r_running  <= r_lock_s;
      end else begin
        r_div_cnt <= (r_div_cnt == c_DIV_LAST) ? '0 : r_div_cnt + 1'b1;
        if (r_div_cnt == c_DIV_LAST) begin
          r_bit_cnt <= (r_bit_cnt == c_BIT_LAST) ? '0 : r_bit_cnt + 1'b1;
        end

        if (w_fall) begin
          r_bclk   <= 1'b0;
          r_lrck   <= w_right;
          r_dacdat <= 1'b0;
          if (r_bit_cnt == '0) begin
            if (r_buf_full) begin
              r_dac_sh_l <= r_buf_l;
              r_dac_sh_r <= r_buf_r;
            end else begin
              r_dac_sh_l <= '0;
              r_dac_sh_r <= '0;
              r_underrun <= 1'b1;
            end
          end else if (w_data_bit) begin
            if (w_right) begin
              r_dacdat   <= r_dac_sh_r[SAMPLE_W-1];
              r_dac_sh_r <= r_dac_sh_r << 1;
            end else begin
              r_dacdat   <= r_dac_sh_l[SAMPLE_W-1];
              r_dac_sh_l <= r_dac_sh_l << 1;
            end
          end
        end

        if (w_rise) begin
          r_bclk <= 1'b1;
          if (w_data_bit) begin
            if (w_right) begin
              r_adc_sh_r <= w_adc_r_nxt;
            end else begin
              r_adc_sh_l <= w_adc_l_nxt;
            end
          end
          if (r_bit_cnt == c_BIT_LAST) begin
            // The last right-slot data bit may land on this same rise when
            // SAMPLE_W = SLOT_W-1, so take the post-shift value then.
            r_adc_l     <= r_adc_sh_l;
            r_adc_r     <= w_data_bit ? w_adc_r_nxt : r_adc_sh_r;
            r_adc_valid <= 1'b1;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_audio_i2s_codec_if.sv
`default_nettype none
// ============================================================================
// Module      : tb_audio_i2s_codec_if
// Description : Directed self-checking bench for audio_i2s_codec_if with an
//               independent I2S decoder on the codec pins and ADC loopback.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_i2s_codec_if;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pll_locked = 1'b0;
  logic [15:0] dac_l = '0;
  logic [15:0] dac_r = '0;
  logic        dac_valid = 1'b0;
  logic        loop_en = 1'b0;
  logic        o_dac_ready, o_dac_underrun, o_adc_valid;
  logic [15:0] o_adc_left, o_adc_right;
  logic        o_aud_bclk, o_aud_lrck, o_aud_dacdat, o_running;
  logic        adcdat;

  assign adcdat = loop_en & o_aud_dacdat;

  always #5 clk = ~clk;

  audio_i2s_codec_if #(.SAMPLE_W(16), .SLOT_W(32), .BCLK_DIV(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_pll_locked   (pll_locked),
    .i_dac_left     (dac_l),
    .i_dac_right    (dac_r),
    .i_dac_valid    (dac_valid),
    .o_dac_ready    (o_dac_ready),
    .o_dac_underrun (o_dac_underrun),
    .o_adc_left     (o_adc_left),
    .o_adc_right    (o_adc_right),
    .o_adc_valid    (o_adc_valid),
    .o_aud_bclk     (o_aud_bclk),
    .o_aud_lrck     (o_aud_lrck),
    .o_aud_dacdat   (o_aud_dacdat),
    .i_aud_adcdat   (adcdat),
    .o_running      (o_running)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Pin-level monitor: I2S decoder, event counters and ADC capture log.
  int          cyc = 0;
  int          pos = -1;
  logic        prev_lrck = 1'b0, prev_bclk = 1'b0, lrck_q = 1'b0, adcv_q = 1'b0;
  logic [15:0] wl = '0, wr = '0, dec_l = '0, dec_r = '0;
  logic        junk = 1'b0, dec_junk = 1'b0;
  int          frames = 0;
  int          last_bclk_rise = -1, bclk_per = 0, last_lrck_rise = -1, lrck_per = 0;
  int          und_cnt = 0, rdy_cnt = 0, adc_bad = 0, last_adcv = -1;
  logic [15:0] adc_ql[$];
  logic [15:0] adc_qr[$];

  always @(negedge clk) begin
    cyc++;
    if (o_dac_underrun) und_cnt++;
    if (dac_valid && o_dac_ready) rdy_cnt++;
    if (o_adc_valid) begin
      adc_ql.push_back(o_adc_left);
      adc_qr.push_back(o_adc_right);
      if (adcv_q) adc_bad++;
      if (last_adcv >= 0 && (cyc - last_adcv) != 256) adc_bad++;
      last_adcv = cyc;
    end
    adcv_q = o_adc_valid;
    if (!o_running) begin
      pos = -1; prev_lrck = 1'b0; prev_bclk = 1'b0; wl = '0; wr = '0; junk = 1'b0;
    end else begin
      if (o_aud_bclk && !prev_bclk) begin
        if (last_bclk_rise >= 0) bclk_per = cyc - last_bclk_rise;
        last_bclk_rise = cyc;
        if (o_aud_lrck != prev_lrck) pos = 0;
        else pos++;
        prev_lrck = o_aud_lrck;
        if (pos >= 1 && pos <= 16) begin
          if (o_aud_lrck) wr = {wr[14:0], o_aud_dacdat};
          else            wl = {wl[14:0], o_aud_dacdat};
        end else if (o_aud_dacdat) begin
          junk = 1'b1;
        end
        if (o_aud_lrck && pos == 31) begin
          dec_l = wl; dec_r = wr; dec_junk = junk; frames++;
          wl = '0; wr = '0; junk = 1'b0;
        end
      end
      if (o_aud_lrck && !lrck_q) begin
        if (last_lrck_rise >= 0) lrck_per = cyc - last_lrck_rise;
        last_lrck_rise = cyc;
      end
      prev_bclk = o_aud_bclk;
    end
    lrck_q = o_aud_lrck;
  end

  logic [15:0] PL [8] = '{16'h3C5A, 16'h8001, 16'h7FFF, 16'h0000,
                          16'hFFFF, 16'h1357, 16'hBEEF, 16'h4321};
  logic [15:0] PR [8] = '{16'hC0DE, 16'h0001, 16'h8000, 16'h5555,
                          16'hAAAA, 16'h2468, 16'hF00D, 16'h0F1E};
  int acc [8];
  int n, base_rdy, base_adc, base_f;

  initial begin
    loop_en = 1'b1;
    tick(3);
    chk("rst_bclk", o_aud_bclk, 0);
    chk("rst_lrck", o_aud_lrck, 0);
    chk("rst_dacdat", o_aud_dacdat, 0);
    chk("rst_running", o_running, 0);
    chk("rst_ready", o_dac_ready, 1);
    chk("rst_adc_valid", o_adc_valid, 0);
    chk("rst_underrun", o_dac_underrun, 0);
    chk("rst_adc_left", o_adc_left, 0);
    chk("rst_adc_right", o_adc_right, 0);
    rst_n = 1'b1;

    // Lock gating
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      tick(1);
      if (o_aud_bclk || o_aud_lrck || o_running) n++;
    end
    chk("gate_idle_active_cycles", n, 0);

    // Preload a pair while idle
    dac_l = 16'hA5C3; dac_r = 16'h1234; dac_valid = 1'b1;
    chk("pre_ready", o_dac_ready, 1);
    tick(1);
    dac_valid = 1'b0;
    chk("buf_full_ready", o_dac_ready, 0);

    // Lock and latency
    pll_locked = 1'b1;
    n = 0;
    while (!o_running && n < 10) begin tick(1); n++; end
    chk("lock_latency_2to3", (n >= 2 && n <= 3), 1);

    // Frame 1: preloaded pair
    n = 0;
    while (frames < 1 && n < 400) begin tick(1); n++; end
    chk("f1_frames", frames, 1);
    chk("f1_left", dec_l, 16'hA5C3);
    chk("f1_right", dec_r, 16'h1234);
    chk("f1_pad_zero", dec_junk, 0);
    chk("bclk_period", bclk_per, 4);
    chk("f1_no_underrun", und_cnt, 0);
    chk("f1_ready", o_dac_ready, 1);

    // Frame 2: underrun
    n = 0;
    while (frames < 2 && n < 300) begin tick(1); n++; end
    chk("f2_frames", frames, 2);
    chk("f2_left_zero", dec_l, 0);
    chk("f2_right_zero", dec_r, 0);
    chk("f2_underrun", und_cnt, 1);
    chk("lrck_period", lrck_per, 256);
    tick(10);
    chk("f3_underrun", und_cnt, 2);

    // Streaming with continuous valid (backpressure + loopback)
    base_rdy = rdy_cnt;
    for (int k = 0; k < 8; k++) begin
      dac_l = PL[k]; dac_r = PR[k]; dac_valid = 1'b1;
      n = 0;
      while (!o_dac_ready && n < 600) begin tick(1); n++; end
      chk("stream_accept", o_dac_ready, 1);
      tick(1);
      acc[k] = cyc;
    end
    dac_valid = 1'b0;
    chk("accept_spacing", acc[7] - acc[1], 6 * 256);
    chk("ready_high_cycles", rdy_cnt - base_rdy, 8);
    n = 0;
    while (adc_ql.size() < 11 && n < 1000) begin tick(1); n++; end
    chk("adc_frame_count", adc_ql.size(), 11);
    chk("adc0_left", adc_ql[0], 16'hA5C3);
    chk("adc0_right", adc_qr[0], 16'h1234);
    chk("adc1_zero", {adc_ql[1], adc_qr[1]}, 0);
    chk("adc2_zero", {adc_ql[2], adc_qr[2]}, 0);
    for (int k = 0; k < 8; k++) begin
      chk("loop_left", adc_ql[3+k], PL[k]);
      chk("loop_right", adc_qr[3+k], PR[k]);
    end
    chk("adc_valid_spacing", adc_bad, 0);
    chk("stream_no_underrun", und_cnt, 2);

    // Lock loss mid-frame with a pair buffered
    n = 0;
    while (und_cnt < 3 && n < 50) begin tick(1); n++; end
    chk("f12_underrun", und_cnt, 3);
    dac_l = 16'h7E81; dac_r = 16'h0F0F; dac_valid = 1'b1;
    tick(1);
    dac_valid = 1'b0;
    chk("q_buffered", o_dac_ready, 0);
    n = 0;
    while (!(pos == 20 && o_aud_lrck == 1'b0) && n < 300) begin tick(1); n++; end
    chk("reach_bit20", pos, 20);
    base_adc = adc_ql.size();
    pll_locked = 1'b0;
    tick(3);
    chk("loss_running", o_running, 0);
    chk("loss_bclk", o_aud_bclk, 0);
    chk("loss_lrck", o_aud_lrck, 0);
    chk("loss_dacdat", o_aud_dacdat, 0);
    tick(50);
    chk("loss_no_adc_valid", adc_ql.size(), base_adc);
    chk("loss_buf_kept", o_dac_ready, 0);

    pll_locked = 1'b1;
    base_f = frames;
    n = 0;
    while (frames < base_f + 1 && n < 400) begin tick(1); n++; end
    chk("relock_frames", frames, base_f + 1);
    chk("relock_left", dec_l, 16'h7E81);
    chk("relock_right", dec_r, 16'h0F0F);
    chk("relock_pad_zero", dec_junk, 0);
    chk("relock_no_underrun", und_cnt, 3);
    n = 0;
    while (adc_ql.size() < base_adc + 1 && n < 20) begin tick(1); n++; end
    chk("relock_adc_left", adc_ql[base_adc], 16'h7E81);
    chk("relock_adc_right", adc_qr[base_adc], 16'h0F0F);

    // Asynchronous reset mid-frame
    n = 0;
    while (!o_aud_lrck && n < 300) begin tick(1); n++; end
    chk("pre_rst_lrck", o_aud_lrck, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_running", o_running, 0);
    chk("arst_lrck", o_aud_lrck, 0);
    chk("arst_adc_left", o_adc_left, 0);
    chk("arst_ready", o_dac_ready, 1);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    chk("post_rst_idle", o_running, 0);
    n = 0;
    while (!o_running && n < 10) begin tick(1); n++; end
    chk("post_rst_relatency", n, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
